gshare_btb_predictor: RTL

Fetch-stage branch predictor combining a gshare pattern history table (PHT) with a direct-mapped branch target buffer (BTB).
- Fetch side: looks up the current fetch PC combinationally and produces the branch_predict_type fields carried in if_id_type: branch_taken_predict, current_GHSR, branch_btb_hit, branch_btb_addr.
- Resolve side: updated from the EX stage when a branch or jump resolves, including GHSR repair on mispredict.

---
 rtl/gshare_btb_predictor_if.sv | 33 +++
 rtl/gshare_btb_predictor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor_if.sv
// Fetch/resolve signal bundle for the gshare + BTB branch predictor.
// The master drives fetch and resolve inputs; the predictor (slave) returns the lookup result.
interface gshare_btb_predictor_if #(
   parameter int XLEN_WIDTH        = 32,
   parameter int GSHARE_GHSR_WIDTH = 10
);
   logic [XLEN_WIDTH-1:0]        fetch_pc;
   logic                         fetch_valid;
   logic                         fetch_stall;
   logic                         pred_taken;
   logic [GSHARE_GHSR_WIDTH-1:0] pred_ghsr;
   logic                         pred_btb_hit;
   logic [XLEN_WIDTH-1:0]        pred_target;
   logic                         upd_valid;
   logic                         upd_is_cond;
   logic [XLEN_WIDTH-1:0]        upd_pc;
   logic                         upd_taken;
   logic [XLEN_WIDTH-1:0]        upd_target;
   logic [GSHARE_GHSR_WIDTH-1:0] upd_ghsr;
   logic                         upd_mispredict;

   modport master (
      output fetch_pc, fetch_valid, fetch_stall,
      output upd_valid, upd_is_cond, upd_pc, upd_taken, upd_target, upd_ghsr, upd_mispredict,
      input  pred_taken, pred_ghsr, pred_btb_hit, pred_target
   );

   modport slave (
      input  fetch_pc, fetch_valid, fetch_stall,
      input  upd_valid, upd_is_cond, upd_pc, upd_taken, upd_target, upd_ghsr, upd_mispredict,
      output pred_taken, pred_ghsr, pred_btb_hit, pred_target
   );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational on pre-edge state; resolve updates and GHSR repair take effect at the edge.
module gshare_btb_predictor #(
   parameter int XLEN_WIDTH        = 32,
   parameter int GSHARE_GHSR_WIDTH = 10,
   parameter int GSHARE_PHT_SIZE   = 1024,
   parameter int GSHARE_PHT_WIDTH  = 10,
   parameter int BTB_ENTRY_NUM     = 512
) (
   input  logic                   clk,
   input  logic                   reset_n,
   gshare_btb_predictor_if.slave  bus
);
   localparam int BTB_IDX_W = $clog2(BTB_ENTRY_NUM);
   localparam int TAG_W     = XLEN_WIDTH - BTB_IDX_W - 2;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken) begin
         if (cnt != 2'b11) res = cnt + 2'b01;
         else              res = cnt;
      end else begin
         if (cnt != 2'b00) res = cnt - 2'b01;
         else              res = cnt;
      end
      return res;
   endfunction

   logic [GSHARE_GHSR_WIDTH-1:0] ghsr_q;
   logic [GSHARE_GHSR_WIDTH-1:0] ghsr_d;
   logic [1:0]                   pht_q [GSHARE_PHT_SIZE];
   logic [BTB_ENTRY_NUM-1:0]     btb_valid_q;
   logic [BTB_ENTRY_NUM-1:0]     btb_cond_q;
   logic [TAG_W-1:0]             btb_tag_q [BTB_ENTRY_NUM];
   logic [XLEN_WIDTH-1:0]        btb_target_q [BTB_ENTRY_NUM];

   logic [BTB_IDX_W-1:0]         fetch_bidx_s;
   logic [TAG_W-1:0]             fetch_tag_s;
   logic [GSHARE_PHT_WIDTH-1:0]  fetch_pidx_s;
   logic                         fetch_hit_s;
   logic                         fetch_cond_s;
   logic                         fetch_taken_s;
   logic [XLEN_WIDTH-1:0]        fetch_target_s;
   logic                         spec_shift_s;

   logic [BTB_IDX_W-1:0]         upd_bidx_s;
   logic [TAG_W-1:0]             upd_tag_s;
   logic [GSHARE_PHT_WIDTH-1:0]  upd_pidx_s;
   logic                         pht_wr_s;
   logic                         btb_wr_s;
   logic [1:0]                   pht_nxt_s;
   logic                         unused_pc_bits_s;

   assign fetch_bidx_s = bus.fetch_pc[BTB_IDX_W+1:2];
   assign fetch_tag_s  = bus.fetch_pc[XLEN_WIDTH-1:BTB_IDX_W+2];
   assign fetch_pidx_s = GSHARE_PHT_WIDTH'(ghsr_q) ^ bus.fetch_pc[GSHARE_PHT_WIDTH+1:2];

   assign upd_bidx_s   = bus.upd_pc[BTB_IDX_W+1:2];
   assign upd_tag_s    = bus.upd_pc[XLEN_WIDTH-1:BTB_IDX_W+2];
   assign upd_pidx_s   = GSHARE_PHT_WIDTH'(bus.upd_ghsr) ^ bus.upd_pc[GSHARE_PHT_WIDTH+1:2];
   assign pht_wr_s     = bus.upd_valid && bus.upd_is_cond;
   assign btb_wr_s     = bus.upd_valid && bus.upd_taken;
   assign pht_nxt_s    = sat_update(pht_q[upd_pidx_s], bus.upd_taken);

   assign unused_pc_bits_s = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

   // Combinational lookup; jumps that hit are always taken, branches follow the PHT MSB.
   always_comb begin
      fetch_hit_s    = btb_valid_q[fetch_bidx_s] && (btb_tag_q[fetch_bidx_s] == fetch_tag_s);
      fetch_cond_s   = btb_cond_q[fetch_bidx_s];
      fetch_taken_s  = 1'b0;
      fetch_target_s = '0;
      if (fetch_hit_s) begin
         fetch_target_s = btb_target_q[fetch_bidx_s];
         if (fetch_cond_s) fetch_taken_s = pht_q[fetch_pidx_s][1];
         else              fetch_taken_s = 1'b1;
      end else begin
         fetch_target_s = '0;
         fetch_taken_s  = 1'b0;
      end
   end

   assign spec_shift_s = bus.fetch_valid && !bus.fetch_stall && fetch_hit_s && fetch_cond_s;

   // Repair from EX outranks the speculative shift issued by fetch in the same cycle.
   always_comb begin
      ghsr_d = ghsr_q;
      if (bus.upd_valid && bus.upd_mispredict) begin
         if (bus.upd_is_cond) ghsr_d = {bus.upd_ghsr[GSHARE_GHSR_WIDTH-2:0], bus.upd_taken};
         else                 ghsr_d = bus.upd_ghsr;
      end else if (spec_shift_s) begin
         ghsr_d = {ghsr_q[GSHARE_GHSR_WIDTH-2:0], fetch_taken_s};
      end else begin
         ghsr_d = ghsr_q;
      end
   end

   // Global history register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ghsr_q <= '0;
      else          ghsr_q <= ghsr_d;
   end

   // Pattern history table: every counter starts weakly not-taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < GSHARE_PHT_SIZE; i++) pht_q[i] <= 2'b01;
      end else if (pht_wr_s) begin
         pht_q[upd_pidx_s] <= pht_nxt_s;
      end
   end

   // BTB control bits; clearing valid is enough to empty the table.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btb_valid_q <= '0;
         btb_cond_q  <= '0;
      end else if (btb_wr_s) begin
         btb_valid_q[upd_bidx_s] <= 1'b1;
         btb_cond_q[upd_bidx_s]  <= bus.upd_is_cond;
      end
   end

   // BTB payload, only meaningful behind a set valid bit.
   always_ff @(posedge clk) begin
      if (btb_wr_s) begin
         btb_tag_q[upd_bidx_s]    <= upd_tag_s;
         btb_target_q[upd_bidx_s] <= bus.upd_target;
      end
   end

   assign bus.pred_taken   = fetch_taken_s;
   assign bus.pred_ghsr    = ghsr_q;
   assign bus.pred_btb_hit = fetch_hit_s;
   assign bus.pred_target  = fetch_target_s;
endmodule
